// File: rtl/int2float_pipe_if.sv
// Stream bundle for the integer-to-minifloat converter: one integer word in,
// one {sign, exponent, mantissa} result plus status flags out.
interface int2float_pipe_if #(
    parameter int IN_W  = 11,
    parameter int MAN_W = 4,
    parameter int EXP_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_rne;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_man;
    logic             out_inexact;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_rne, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man, out_inexact, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_rne, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man, out_inexact, out_ovf
    );
endinterface

// File: rtl/int2float_pipe.sv
// Two-stage integer-to-minifloat converter: stage 1 takes the magnitude and
// leading-one position, stage 2 encodes, rounds and saturates.
module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int MAN_W  = 4,
    parameter int EXP_W  = 3,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    int2float_pipe_if.slave bus
);
    localparam int PW     = $clog2(IN_W);
    localparam int EW1    = EXP_W + 1;
    localparam int MW1    = MAN_W + 1;
    localparam int STAGES = 2;

    if (IN_W < MAN_W + 2) begin : g_bad_in_w
        $error("int2float_pipe: IN_W must be at least MAN_W+2");
    end
    if ((1 << EXP_W) - 1 < IN_W - MAN_W) begin : g_bad_exp_w
        $error("int2float_pipe: EXP_W too narrow for IN_W-MAN_W");
    end

    typedef struct packed {
        logic [IN_W-1:0] mag;
        logic [PW-1:0]   pos;
        logic            sign;
        logic            rne;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             inexact;
        logic             ovf;
    } res_t;

    logic            en;
    logic [STAGES:1] vld_pipe;
    logic            neg;
    s1_t             s1_d, s1_q;
    res_t            res_d, res_q;

    logic [PW-1:0]   shamt;
    logic [IN_W-1:0] lowmask;
    logic [MAN_W-1:0] man;
    logic [MW1-1:0]  man_sum;
    logic [EW1-1:0]  e_full;
    logic            g, st, rup;

    // A single stall signal freezes every stage, so held outputs stay put.
    assign en            = ~vld_pipe[STAGES] | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_sign    = res_q.sign;
    assign bus.out_exp     = res_q.exp;
    assign bus.out_man     = res_q.man;
    assign bus.out_inexact = res_q.inexact;
    assign bus.out_ovf     = res_q.ovf;

    always_comb begin
        neg        = (SIGNED != 0) && bus.in_data[IN_W-1];
        s1_d.sign  = neg;
        s1_d.rne   = bus.in_rne;
        // IN_W-bit negate maps -2^(IN_W-1) onto its unsigned magnitude.
        s1_d.mag   = neg ? (~bus.in_data + IN_W'(1)) : bus.in_data;
        s1_d.pos   = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (s1_d.mag[i]) s1_d.pos = PW'(i);
        end
    end

    always_comb begin
        shamt   = '0;
        lowmask = '0;
        g       = 1'b0;
        st      = 1'b0;
        e_full  = '0;
        man     = s1_q.mag[MAN_W-1:0];
        if (|s1_q.mag[IN_W-1:MAN_W]) begin
            shamt   = s1_q.pos - PW'(MAN_W);
            lowmask = (IN_W'(1) << shamt) - IN_W'(1);
            man     = MAN_W'(s1_q.mag >> shamt);
            e_full  = EW1'(shamt) + EW1'(1);
            // Guard is the top discarded bit, sticky everything below it.
            g       = |(s1_q.mag & lowmask & ~(lowmask >> 1));
            st      = |(s1_q.mag & (lowmask >> 1));
        end
        rup     = s1_q.rne & g & (st | man[0]);
        man_sum = {1'b0, man} + MW1'(rup);
        if (man_sum[MAN_W]) e_full = e_full + EW1'(1);

        res_d.sign    = s1_q.sign;
        res_d.exp     = e_full[EXP_W-1:0];
        res_d.man     = man_sum[MAN_W-1:0];
        res_d.inexact = g | st;
        res_d.ovf     = 1'b0;
        if (e_full[EXP_W]) begin
            res_d.exp     = '1;
            res_d.man     = '1;
            res_d.inexact = 1'b1;
            res_d.ovf     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            res_q    <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
            if (bus.in_valid) s1_q  <= s1_d;
            if (vld_pipe[1])  res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_int2float_pipe.sv
// Directed bench for int2float_pipe: unsigned and signed instances, an
// arithmetic reference model with a per-cycle scoreboard, literal spot checks.
module tb_int2float_pipe;
    localparam int IN_W  = 11;
    localparam int MAN_W = 4;
    localparam int EXP_W = 3;

    typedef struct packed {
        logic        id;
        logic [10:0] data;
        logic        rne;
        logic [9:0]  exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_out [2];
    logic [9:0] qu [$];
    logic [9:0] qs [$];
    logic       stalled [2];
    logic [9:0] held [2];
    vec_t       vecs [17];
    logic [10:0] bp_w [8];
    logic        bp_r [16];

    int2float_pipe_if #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) bu ();
    int2float_pipe_if #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) bs ();

    int2float_pipe #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .bus(bu)
    );
    int2float_pipe #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bs)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: scale the magnitude into [2^MAN_W, 2^(MAN_W+1)) and round the remainder.
    function automatic logic [9:0] model(input logic [10:0] raw, input logic rne, input logic sgn);
        int v, k, q, rem, half, e;
        logic neg, inx;
        logic [2:0] e3;
        logic [3:0] m4;
        neg = sgn && raw[10];
        v   = int'(raw);
        if (neg) v = (1 << IN_W) - v;
        if (v < (1 << MAN_W)) begin
            m4 = v[3:0];
            return {neg, 3'd0, m4, 2'b00};
        end
        k = 0;
        while ((v >> (k + 1)) >= (1 << MAN_W)) k++;
        q   = v >> k;
        rem = v - (q << k);
        inx = (rem != 0);
        if (rne && k > 0) begin
            half = 1 << (k - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end
        if (q == (1 << (MAN_W + 1))) begin
            q = q >> 1;
            k++;
        end
        e = k + 1;
        if (e > (1 << EXP_W) - 1) return {neg, 3'b111, 4'b1111, 2'b11};
        e3 = e[2:0];
        q  = q - (1 << MAN_W);
        m4 = q[3:0];
        return {neg, e3, m4, inx, 1'b0};
    endfunction

    function automatic logic [9:0] obs(input logic id);
        if (id == 1'b0) return {bu.out_sign, bu.out_exp, bu.out_man, bu.out_inexact, bu.out_ovf};
        return {bs.out_sign, bs.out_exp, bs.out_man, bs.out_inexact, bs.out_ovf};
    endfunction

    function automatic logic ovalid(input logic id);
        return id ? bs.out_valid : bu.out_valid;
    endfunction

    task automatic drive(input logic id, input logic v, input logic [10:0] d, input logic r);
        if (id == 1'b0) begin
            bu.in_valid = v; bu.in_data = d; bu.in_rne = r;
        end else begin
            bs.in_valid = v; bs.in_data = d; bs.in_rne = r;
        end
    endtask

    task automatic sb_step(input int id, input logic ov, input logic ordy, input logic iv,
                           input logic irdy, input logic [10:0] din, input logic rne,
                           input logic [9:0] got);
        logic [9:0] exp;
        logic       exp_rdy;
        int         sz;
        exp_rdy = ~ov | ordy;
        chk($sformatf("in_ready_%0d", id), {31'd0, irdy}, {31'd0, exp_rdy});
        if (stalled[id]) chk($sformatf("held_%0d", id), {21'd0, ov, got}, {21'd0, 1'b1, held[id]});
        stalled[id] = ov & ~ordy;
        held[id]    = got;
        sz = (id == 0) ? qu.size() : qs.size();
        if (sz == 0) begin
            chk($sformatf("spurious_out_%0d", id), {31'd0, ov}, 32'd0);
        end else if (ov) begin
            exp = (id == 0) ? qu[0] : qs[0];
            chk($sformatf("result_%0d", id), {22'd0, got}, {22'd0, exp});
            if (ordy) begin
                if (id == 0) void'(qu.pop_front());
                else         void'(qs.pop_front());
                n_out[id]++;
            end
        end
        if (iv & irdy) begin
            if (id == 0) qu.push_back(model(din, rne, 1'b0));
            else         qs.push_back(model(din, rne, 1'b1));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            qu.delete();
            qs.delete();
            for (int j = 0; j < 2; j++) stalled[j] = 1'b0;
            chk("rst_out_valid_u", {31'd0, bu.out_valid}, 32'd0);
            chk("rst_out_valid_s", {31'd0, bs.out_valid}, 32'd0);
        end else begin
            sb_step(0, bu.out_valid, bu.out_ready, bu.in_valid, bu.in_ready, bu.in_data, bu.in_rne, obs(1'b0));
            sb_step(1, bs.out_valid, bs.out_ready, bs.in_valid, bs.in_ready, bs.in_data, bs.in_rne, obs(1'b1));
        end
    end

    task automatic send_chk(input vec_t v);
        int n;
        drive(v.id, 1'b1, v.data, v.rne);
        @(posedge clk); #1;
        drive(v.id, 1'b0, 11'd0, 1'b0);
        n = 1;
        while (!ovalid(v.id) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("latency_%0d_%0d", v.data, v.rne), n, 2);
        chk($sformatf("model_%0d_%0d", v.data, v.rne), {22'd0, model(v.data, v.rne, v.id)}, {22'd0, v.exp});
        chk($sformatf("direct_%0d_%0d", v.data, v.rne), {22'd0, obs(v.id)}, {22'd0, v.exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, i, guard;
        logic take;
        n_out[0] = 0; n_out[1] = 0;
        stalled[0] = 1'b0; stalled[1] = 1'b0;
        held[0] = '0; held[1] = '0;
        vecs = '{
            '{1'b0, 11'd0,    1'b0, 10'b0_000_0000_00},
            '{1'b0, 11'd15,   1'b0, 10'b0_000_1111_00},
            '{1'b0, 11'd16,   1'b0, 10'b0_001_0000_00},
            '{1'b0, 11'd1984, 1'b0, 10'b0_111_1111_00},
            '{1'b0, 11'd37,   1'b0, 10'b0_010_0010_10},
            '{1'b0, 11'd37,   1'b1, 10'b0_010_0010_10},
            '{1'b0, 11'd39,   1'b0, 10'b0_010_0011_10},
            '{1'b0, 11'd39,   1'b1, 10'b0_010_0100_10},
            '{1'b0, 11'd47,   1'b1, 10'b0_010_1000_10},
            '{1'b0, 11'd2047, 1'b0, 10'b0_111_1111_10},
            '{1'b0, 11'd2047, 1'b1, 10'b0_111_1111_11},
            '{1'b0, 11'd1023, 1'b1, 10'b0_111_0000_10},
            '{1'b1, 11'd2032, 1'b0, 10'b1_001_0000_00},
            '{1'b1, 11'd1024, 1'b0, 10'b1_111_0000_00},
            '{1'b1, 11'd2043, 1'b0, 10'b1_000_0101_00},
            '{1'b1, 11'd0,    1'b1, 10'b0_000_0000_00},
            '{1'b1, 11'd1023, 1'b0, 10'b0_110_1111_10}
        };
        bp_w = '{11'd100, 11'd200, 11'd300, 11'd17, 11'd18, 11'd1000, 11'd2047, 11'd33};
        bp_r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        drive(1'b0, 1'b0, 11'd0, 1'b0);
        drive(1'b1, 1'b0, 11'd0, 1'b0);
        bu.out_ready = 1'b1;
        bs.out_ready = 1'b1;

        #1;
        chk("reset_state_u", {21'd0, bu.out_valid, obs(1'b0)}, 32'd0);
        chk("reset_state_s", {21'd0, bs.out_valid, obs(1'b1)}, 32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", {31'd0, bu.in_ready}, 32'd1);

        for (int k = 0; k < 17; k++) send_chk(vecs[k]);

        // Back-to-back stream with a three-cycle stall and a one-cycle blip.
        base = n_out[0];
        fork
            begin
                i = 0;
                guard = 0;
                while (i < 8 && guard < 100) begin
                    drive(1'b0, 1'b1, bp_w[i], i[0]);
                    @(negedge clk);
                    take = bu.in_ready;
                    @(posedge clk); #1;
                    if (take) i++;
                    guard++;
                end
                drive(1'b0, 1'b0, 11'd0, 1'b0);
                chk("bp_all_sent", i, 8);
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    bu.out_ready = bp_r[c];
                    @(posedge clk); #1;
                end
                bu.out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 20 && qu.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("bp_count", n_out[0] - base, 8);
        chk("bp_drain", qu.size(), 0);

        // Async reset with two words in flight.
        drive(1'b0, 1'b1, 11'd500, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 11'd600, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 11'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bu.out_valid}, 32'd0);
        chk("async_rst_data", {22'd0, obs(1'b0)}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("no_stale_output", {31'd0, bu.out_valid}, 32'd0);
        end
        send_chk(vecs[2]);
        send_chk(vecs[10]);

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("final_queue_u", qu.size(), 0);
        chk("final_queue_s", qs.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
